// File: rtl/histogram_equalizer_lut.sv
// Builds a double-buffered 256-entry equalisation LUT from histogram bins and remaps pixels (1-cycle latency).
// No backpressure: bins are read at one per cycle, and pixels are accepted whenever in_valid_i is high.
module histogram_equalizer_lut #(
  parameter int PIX_SHIFT = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hist_valid_i,
  output logic             hist_rd_en_o,
  output logic [7:0]       hist_addr_o,
  input  logic [CNT_W-1:0] hist_data_i,
  input  logic [7:0]       in_pixel_i,
  input  logic             in_valid_i,
  input  logic             in_end_of_frame_i,
  output logic [7:0]       out_pixel_o,
  output logic             out_valid_o,
  output logic             out_end_of_frame_o,
  output logic             busy_o,
  output logic             build_done_o,
  output logic [CNT_W-1:0] cdf_total_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             start_evt, done_evt, rd_en_d;
  logic [7:0]       addr_d;

  logic             rd_en_q;
  logic [7:0]       addr_q;
  logic             s1_vld_q;
  logic [7:0]       s1_addr_q;
  logic             s2_vld_q;
  logic [7:0]       s2_addr_q;
  logic [CNT_W-1:0] cdf_q;
  logic [CNT_W-1:0] cdf_total_q;
  logic             build_done_q;

  logic             swap_pend_q;
  logic             lut_loaded_q;
  logic             bank_q;
  logic             swap_evt;

  logic [7:0]       out_pixel_q;
  logic             out_valid_q;
  logic             out_eof_q;

  logic [CNT_W+7:0] prod;
  logic [CNT_W+7:0] scaled;
  logic [7:0]       lut_wdat;

  logic [7:0]       lut_mem [512];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // cnt_q walks the bin addresses in RUN, then times the two FLUSH cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (hist_valid_i) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd255) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_DONE;
          cnt_d   = 8'd0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    start_evt = 1'b0;
    done_evt  = 1'b0;
    rd_en_d   = 1'b0;
    addr_d    = 8'd0;
    busy_o    = 1'b0;
    case (state_q)
      S_IDLE:  start_evt = hist_valid_i;
      S_RUN: begin
        rd_en_d = 1'b1;
        addr_d  = cnt_q;
        busy_o  = 1'b1;
      end
      S_FLUSH: busy_o = 1'b1;
      S_DONE: begin
        done_evt = 1'b1;
        busy_o   = 1'b1;
      end
      default: busy_o = 1'b0;
    endcase
  end

  // ---------------- Build pipeline ----------------
  // Read request -> data returns one cycle later (s1) -> accumulated CDF is scaled and written (s2).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_en_q      <= 1'b0;
      addr_q       <= 8'd0;
      s1_vld_q     <= 1'b0;
      s1_addr_q    <= 8'd0;
      s2_vld_q     <= 1'b0;
      s2_addr_q    <= 8'd0;
      cdf_q        <= '0;
      cdf_total_q  <= '0;
      build_done_q <= 1'b0;
    end else begin
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      s1_vld_q     <= rd_en_q;
      s1_addr_q    <= addr_q;
      s2_vld_q     <= s1_vld_q;
      s2_addr_q    <= s1_addr_q;
      build_done_q <= done_evt;
      if (start_evt) begin
        cdf_q <= '0;
      end else if (s1_vld_q) begin
        cdf_q <= cdf_q + hist_data_i;
      end
      if (done_evt) cdf_total_q <= cdf_q;
    end
  end

  // cdf*255 computed as a shift-and-subtract, then normalised to the frame size.
  always_comb begin
    prod     = {cdf_q, 8'd0} - {8'd0, cdf_q};
    scaled   = prod >> PIX_SHIFT;
    lut_wdat = (|scaled[CNT_W+7:8]) ? 8'hFF : scaled[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (s2_vld_q) lut_mem[{~bank_q, s2_addr_q}] <= lut_wdat;
  end

  // ---------------- Bank control and remap ----------------
  assign swap_evt = swap_pend_q & in_valid_i & in_end_of_frame_i;

  // A completed build takes priority over a swap, so a DONE on the eof edge waits a frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      swap_pend_q  <= 1'b0;
      lut_loaded_q <= 1'b0;
      bank_q       <= 1'b0;
      out_pixel_q  <= 8'd0;
      out_valid_q  <= 1'b0;
      out_eof_q    <= 1'b0;
    end else begin
      if (done_evt) begin
        swap_pend_q  <= 1'b1;
        lut_loaded_q <= 1'b1;
      end else if (start_evt || swap_evt) begin
        swap_pend_q  <= 1'b0;
      end
      if (swap_evt) bank_q <= ~bank_q;
      out_valid_q <= in_valid_i;
      out_eof_q   <= in_end_of_frame_i;
      if (in_valid_i) begin
        out_pixel_q <= lut_loaded_q ? lut_mem[{bank_q, in_pixel_i}] : in_pixel_i;
      end
    end
  end

  assign hist_rd_en_o       = rd_en_q;
  assign hist_addr_o        = addr_q;
  assign build_done_o       = build_done_q;
  assign cdf_total_o        = cdf_total_q;
  assign out_pixel_o        = out_pixel_q;
  assign out_valid_o        = out_valid_q;
  assign out_end_of_frame_o = out_eof_q;

endmodule

// File: tb/tb_histogram_equalizer_lut.sv
// Bench for histogram_equalizer_lut: table vectors, directed corner sequences and randomized builds.
module tb_histogram_equalizer_lut;
  localparam int PIX_SHIFT = 16;
  localparam int CNT_W     = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             hist_valid = 1'b0;
  logic             hist_rd_en;
  logic [7:0]       hist_addr;
  logic [CNT_W-1:0] hist_data;
  logic [7:0]       in_pixel = 8'd0;
  logic             in_valid = 1'b0;
  logic             in_eof = 1'b0;
  logic [7:0]       out_pixel;
  logic             out_valid, out_eof, busy, build_done;
  logic [CNT_W-1:0] cdf_total;

  histogram_equalizer_lut #(.PIX_SHIFT(PIX_SHIFT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .hist_valid_i(hist_valid),
    .hist_rd_en_o(hist_rd_en), .hist_addr_o(hist_addr), .hist_data_i(hist_data),
    .in_pixel_i(in_pixel), .in_valid_i(in_valid), .in_end_of_frame_i(in_eof),
    .out_pixel_o(out_pixel), .out_valid_o(out_valid), .out_end_of_frame_o(out_eof),
    .busy_o(busy), .build_done_o(build_done), .cdf_total_o(cdf_total)
  );

  always #5 clk = ~clk;

  // Histogram RAM of the upstream calculator: data appears the cycle after the read.
  logic [CNT_W-1:0] hist_mem [256];
  always @(posedge clk) hist_data <= hist_rd_en ? hist_mem[hist_addr] : '0;

  int errors = 0;
  int checks = 0;

  // Reference model: the mapping currently applied and the one waiting for a frame boundary.
  int     cur_map [256];
  int     pend_map [256];
  bit     m_loaded, m_pend, m_cur_valid;
  longint m_total;
  int     last_out;

  typedef struct packed {
    logic [7:0] pix;
    logic [7:0] exp;
  } vec_t;
  vec_t t_spike [8];
  vec_t t_unif [9];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_lut(input longint c);
    longint v;
    v = (c * 255) >>> PIX_SHIFT;
    return (v > 255) ? 255 : int'(v);
  endfunction

  task automatic compute_pending();
    longint c;
    c = 0;
    for (int k = 0; k < 256; k++) begin
      c = (c + longint'(hist_mem[k])) & 64'hFFFF_FFFF;
      pend_map[k] = ref_lut(c);
    end
    m_total = c;
  endtask

  function automatic int exp_pix(input int p);
    if (!m_loaded) return p;
    if (!m_cur_valid) return -1;
    return cur_map[p];
  endfunction

  task automatic model_reset();
    m_loaded = 0; m_pend = 0; m_cur_valid = 0; last_out = 0;
  endtask

  task automatic fill_hist(input int mode);
    for (int k = 0; k < 256; k++) begin
      case (mode)
        0: hist_mem[k] = 32'd256;
        1: hist_mem[k] = (k == 128) ? 32'd65536 : 32'd0;
        2: hist_mem[k] = 32'($urandom_range(0, 520));
        default: hist_mem[k] = $urandom;
      endcase
    end
  endtask

  task automatic send_pixel(input int p, input bit eof, output int got);
    int e;
    e = exp_pix(p);
    in_pixel = 8'(p); in_valid = 1'b1; in_eof = eof;
    @(posedge clk); #1;
    in_valid = 1'b0; in_eof = 1'b0;
    chk("out_valid", out_valid, 1);
    chk("out_eof", out_eof, eof);
    if (e >= 0) chk("out_pixel", out_pixel, e);
    got = out_pixel;
    last_out = e;
    if (eof && m_pend) begin
      cur_map = pend_map; m_cur_valid = 1; m_pend = 0;
    end
  endtask

  task automatic idle_cycle();
    in_pixel = 8'($urandom);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", out_valid, 0);
    if (last_out >= 0) chk("hold_pixel", out_pixel, last_out);
  endtask

  task automatic stream_frame(input int n, input bit with_eof);
    int g;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      send_pixel(int'($urandom_range(0, 255)), with_eof && (i == n - 1), g);
    end
  endtask

  // Pulses hist_valid and follows the build cycle by cycle (c = cycles after the sampling edge).
  task automatic run_build(input bit inj_busy, input bit eof_at_done, input int abort_at);
    int reads, dones, old_exp, pp;
    reads = 0; dones = 0; old_exp = -1; pp = 0;
    hist_valid = 1'b1;
    @(posedge clk); #1;
    hist_valid = 1'b0;
    m_pend = 0;
    chk("busy_after_start", busy, 1);
    for (int c = 1; c <= 270; c++) begin
      if (inj_busy && (c == 10 || c == 100)) hist_valid = 1'b1;
      if (eof_at_done && c == 259) begin
        pp = int'($urandom_range(0, 255));
        old_exp = exp_pix(pp);
        in_pixel = 8'(pp); in_valid = 1'b1; in_eof = 1'b1;
      end
      @(posedge clk); #1;
      hist_valid = 1'b0; in_valid = 1'b0; in_eof = 1'b0;
      if (abort_at >= 0 && c == abort_at + 1) begin
        chk("addr_before_abort", hist_addr, abort_at);
        rst_n = 1'b0;
        #1;
        chk("abort_rd_en", hist_rd_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_pixel", out_pixel, 0);
        model_reset();
        #1 rst_n = 1'b1;
        return;
      end
      chk("rd_en_window", hist_rd_en, (c >= 1 && c <= 256) ? 1 : 0);
      if (hist_rd_en) begin
        chk("rd_addr", hist_addr, reads);
        reads++;
      end
      if (build_done) begin
        dones++;
        chk("done_cycle", c, 259);
      end
      if (eof_at_done && c == 259) begin
        chk("eof_at_done_valid", out_eof, 1);
        if (old_exp >= 0) chk("eof_at_done_old_map", out_pixel, old_exp);
        last_out = old_exp;
      end
    end
    chk("read_count", reads, 256);
    chk("done_pulses", dones, 1);
    compute_pending();
    chk("cdf_total", cdf_total, m_total);
    m_pend = 1; m_loaded = 1;
  endtask

  initial begin
    int g;
    t_spike[0] = {8'd0, 8'd0};     t_spike[1] = {8'd1, 8'd0};
    t_spike[2] = {8'd64, 8'd0};    t_spike[3] = {8'd127, 8'd0};
    t_spike[4] = {8'd128, 8'd255}; t_spike[5] = {8'd129, 8'd255};
    t_spike[6] = {8'd200, 8'd255}; t_spike[7] = {8'd255, 8'd255};
    t_unif[0] = {8'd0, 8'd0};      t_unif[1] = {8'd1, 8'd1};
    t_unif[2] = {8'd10, 8'd10};    t_unif[3] = {8'd63, 8'd63};
    t_unif[4] = {8'd127, 8'd127};  t_unif[5] = {8'd128, 8'd128};
    t_unif[6] = {8'd200, 8'd200};  t_unif[7] = {8'd254, 8'd254};
    t_unif[8] = {8'd255, 8'd255};

    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state and identity mapping
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", hist_rd_en, 0);
    chk("rst_build_done", build_done, 0);
    chk("rst_cdf_total", cdf_total, 0);
    for (int p = 0; p < 256; p++) send_pixel(p, 1'b0, g);
    chk("id_busy", busy, 0);
    chk("id_rd_en", hist_rd_en, 0);
    idle_cycle();

    // Single-bin spike: step mapping after the swap
    fill_hist(1);
    run_build(1'b0, 1'b0, -1);
    chk("spike_total", cdf_total, 65536);
    send_pixel(7, 1'b1, g);
    for (int i = 0; i < 8; i++) begin
      send_pixel(int'(t_spike[i].pix), 1'b0, g);
      chk("spike_table", g, t_spike[i].exp);
    end

    // Uniform histogram: the spike map stays active until the eof
    fill_hist(0);
    run_build(1'b0, 1'b0, -1);
    send_pixel(100, 1'b0, g);
    chk("unif_pre_swap", g, 0);
    send_pixel(200, 1'b1, g);
    chk("unif_eof_old_map", g, 255);
    for (int i = 0; i < 9; i++) begin
      send_pixel(int'(t_unif[i].pix), 1'b0, g);
      chk("unif_table", g, t_unif[i].exp);
    end

    // DONE on the eof edge: uniform map persists a whole frame
    fill_hist(1);
    run_build(1'b0, 1'b1, -1);
    send_pixel(100, 1'b0, g);
    chk("coinc_old_frame", g, 100);
    stream_frame(20, 1'b1);
    send_pixel(100, 1'b0, g);
    chk("coinc_new_frame", g, 0);

    // hist_valid during a build is ignored
    fill_hist(2);
    run_build(1'b1, 1'b0, -1);
    repeat (3) idle_cycle();
    chk("no_second_build", busy, 0);
    stream_frame(10, 1'b1);
    stream_frame(10, 1'b0);

    // Reset mid-build, identity resumes, rebuild starts at addr 0
    fill_hist(2);
    run_build(1'b0, 1'b0, 50);
    @(posedge clk); #1;
    for (int p = 250; p < 256; p++) send_pixel(p, 1'b0, g);
    chk("post_abort_busy", busy, 0);
    fill_hist(2);
    run_build(1'b0, 1'b0, -1);
    stream_frame(10, 1'b1);
    stream_frame(15, 1'b0);

    // Randomized builds, occasionally rebuilding over a pending bank
    for (int r = 0; r < 5; r++) begin
      fill_hist((r == 2) ? 3 : 2);
      run_build(1'b0, 1'b0, -1);
      stream_frame(int'($urandom_range(5, 30)), ($urandom_range(0, 2) != 0));
      stream_frame(int'($urandom_range(5, 30)), 1'b1);
      stream_frame(int'($urandom_range(5, 20)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
